nibble_serial_tx: RTL
=====================

# nibble_serial_tx

Downstream drain stage for the nibble FIFO: pops one DATA_WIDTH-bit word whenever the FIFO is non-empty and transmits it on a single serial line as an asynchronous frame. The frame is start bit, data LSB first, optional parity, stop bit. It connects directly to the FIFO read side (rd, empty, r_data) and drives the board-level serial output. Provides back-to-back framing with no idle gap while data is available.

## Interface
- DATA_WIDTH, 4: width of a FIFO read word and of the frame payload.
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  when high, new frames may start; when low, no new pop occurs, and any frame in progress completes.
- empty  input  1  FIFO empty flag.
- r_data  input  DATA_WIDTH  FIFO head word; valid combinationally while empty is low (show-ahead).
- rd  output  1  FIFO pop strobe; one cycle per word consumed.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (states START through STOP).

## Operation
- States: IDLE, START, DATA, PARITY (only with parity compiled in), STOP.
- Pop condition: `pop = en & ~empty & (state==IDLE | (state==STOP & last_tick))`.
  - rd = pop, combinational.
  - On the pop edge, r_data is captured into the shift register and the state goes to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After DATA_WIDTH bits, go to PARITY if compiled in, else STOP.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On last_tick:
  - if pop, go to START (back-to-back frame);
  - else go to IDLE.
- Tick counter:
  - width $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1;
  - last_tick = (count == CLKS_PER_BIT-1);
  - cleared on every state change.
- Bit counter width: $clog2(DATA_WIDTH)+1, so it has no wrap ambiguity at DATA_WIDTH.
- tx, busy and state are registered outputs, so the line is glitch-free. Only rd is combinational.
- Boundary conditions:
  - empty high in IDLE: rd=0, tx=1, busy=0, indefinitely.
  - empty rising mid-frame: the current frame completes; no further pop.
  - en falling mid-frame: the frame completes; no pop at STOP last_tick; the block goes to IDLE.
  - rd is never asserted while empty=1, so the FIFO is never underflowed.
  - reset mid-frame: immediate abort; tx=1, busy=0, rd=0, state=IDLE, counters=0. The partially sent word is lost and is not re-popped.

## Timing
- Reset values: tx=1, busy=0, rd=0, state=IDLE, shift=0, counters=0.
- Pop-to-line latency: tx falls on the clock edge that performs the pop; busy rises on the same edge.
- Frame length: (2 + DATA_WIDTH + P) × CLKS_PER_BIT cycles, where P=1 if parity is compiled in, else 0.
- Back-to-back frames: the next start bit follows the stop bit with zero idle cycles.
- From IDLE with data present: exactly one cycle in IDLE (the pop cycle) before START.
- rd is high for exactly one cycle per frame.

## Configuration
- NIBBLE_TX_PARITY_EN defined:
  - the PARITY state exists;
  - the parity bit is even parity, i.e. XOR of the captured word;
  - frame = 1 + DATA_WIDTH + 1 + 1 bits.
- NIBBLE_TX_PARITY_EN undefined:
  - the PARITY state and parity logic are absent;
  - frame = DATA_WIDTH + 2 bits.

## Test plan
All scenarios use DATA_WIDTH=4 and CLKS_PER_BIT=4.
- Idle: reset released, empty=1, en=1 for 50 cycles -> tx=1, rd=0, busy=0 throughout.
- Single word, no parity: empty low with r_data=4'hA for one pop, then empty high.
  - rd pulses exactly once.
  - tx sequence, 4 cycles each: 0, 0,1,0,1, 1 (24 cycles).
  - busy is high for exactly 24 cycles.
- Back-to-back: FIFO holds 4'h1 then 4'h2.
  - Two rd pulses exactly 24 cycles apart.
  - tx carries frames 0-1000-1 and 0-0100-1 with no high gap between them.
  - 48 cycles total busy.
- Enable gating: en=0 with FIFO non-empty -> no rd, tx=1. Drop en mid-frame -> the frame finishes and no second pop occurs.
- Reset mid-frame: assert reset during the DATA state.
  - tx=1, busy=0 asynchronously.
  - After release with the FIFO non-empty, a fresh frame starts with the next word.
- Parity (macro defined): r_data=4'h7 -> tx = 0, 1,1,1,0, parity 1, stop 1; frame is 28 cycles.

Source files
------------

// File: rtl/nibble_serial_tx.sv
// Drains the nibble FIFO onto an asynchronous serial line: start, data LSB first, [parity], stop.
// Define NIBBLE_TX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module nibble_serial_tx #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef NIBBLE_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
`ifdef NIBBLE_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic last_tick;
  logic pop;

  always_comb begin
    last_tick = (tick_q == TICK_LAST);
    // Reset is folded in so the FIFO never sees a pop while the block is held in reset.
    pop = en & ~empty & ~reset &
          ((state_q == S_IDLE) | ((state_q == S_STOP) & last_tick));
  end

  assign rd = pop;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
`ifdef NIBBLE_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d  = S_START;
          shift_d  = r_data;
          bit_d    = '0;
`ifdef NIBBLE_TX_PARITY_EN
          parity_d = ^r_data;
`endif
        end
      end
      S_START: begin
        if (last_tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (last_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef NIBBLE_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef NIBBLE_TX_PARITY_EN
      S_PARITY: begin
        if (last_tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (last_tick) begin
          if (pop) begin
            state_d  = S_START;
            shift_d  = r_data;
            bit_d    = '0;
`ifdef NIBBLE_TX_PARITY_EN
            parity_d = ^r_data;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The tick counter also wraps at each data bit boundary, where the state does not change.
  always_comb begin
    if ((state_q == S_IDLE) || (state_d != state_q) || last_tick) tick_d = '0;
    else                                                            tick_d = tick_q + 1'b1;
  end

  // Line level is decoded from the next state so tx is a clean register output.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef NIBBLE_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef NIBBLE_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
